aurora_rx_frame_buffer: RTL
===========================

Name: aurora_rx_frame_buffer

Overview:
- Receive-side user endpoint for the 8B/10B Aurora channel, clocked in the user clock domain.
- Absorbs the channel's RX AXI-Stream, which has no backpressure, and stores complete frames in a store-and-forward FIFO.
- Re-emits only committed, error-free frames on a backpressured AXI-Stream master.
- Discards partial, errored and overflowing frames cleanly, so the downstream consumer never sees a truncated frame.

Parameters:
- DATA_W, 32: stream data width in bits; bit 0 is MSB, matching the channel's [0:31] ordering.
- KEEP_W, 4: byte-enable width, DATA_W/8; keep bit 0 qualifies data bits [0:7].
- DEPTH, 512: FIFO depth in words; must be a power of 2, minimum 4.
- ADDR_W, $clog2(DEPTH): derived; pointers are ADDR_W+1 bits wide.

Ports:
- i_clk, in, 1: user clock, same clock as the channel user clock.
- i_rst_n, in, 1: asynchronous, active-low reset.
- s_axi_rx_tdata, in, [0:DATA_W-1]: RX data from the channel.
- s_axi_rx_tkeep, in, [0:KEEP_W-1]: RX byte enables.
- s_axi_rx_tlast, in, 1: end of frame.
- s_axi_rx_tvalid, in, 1: beat valid; there is no tready.
- i_frame_err, in, 1: channel frame error flag.
- i_channel_up, in, 1: channel status.
- m_axi_usr_tdata, out, [0:DATA_W-1]: buffered data.
- m_axi_usr_tkeep, out, [0:KEEP_W-1]: buffered byte enables.
- m_axi_usr_tlast, out, 1: buffered end of frame.
- m_axi_usr_tvalid, out, 1: output beat valid.
- m_axi_usr_tready, in, 1: downstream ready.
- o_free, out, ADDR_W+1: free words, DEPTH-(wr_ptr-rd_ptr).
- o_drop, out, 1: one-cycle pulse per discarded frame.
- o_frame_cnt, out, 16: delivered-frame counter (feature-gated).
- o_drop_cnt, out, 16: dropped-frame counter (feature-gated).

Behaviour:
- Reset: every output is 0, except o_free = DEPTH.
  - wr_ptr, wr_commit and rd_ptr are 0.
  - Write FSM is in IDLE.
  - Reset mid-frame loses all stored and partial data.
- Storage: each memory entry holds {tdata, tkeep, tlast}.
  - wr_ptr is the tentative write pointer; wr_commit is the last frame boundary.
  - Reader sees data only when rd_ptr != wr_commit.
- Write FSM, with states IDLE, RECV and DROP. "Beat" means s_axi_rx_tvalid=1.
- IDLE/RECV, with space available (wr_ptr-rd_ptr < DEPTH), i_frame_err=0 and i_channel_up=1:
  - Write the beat and increment wr_ptr.
  - On tlast: wr_commit <= wr_ptr+1, go to IDLE.
  - Otherwise go to RECV.
- IDLE/RECV, beat arrives while full, or with i_frame_err=1:
  - wr_ptr <= wr_commit (rollback) and pulse o_drop.
  - If tlast, go to IDLE; otherwise go to DROP.
- i_frame_err=1 without a beat while in RECV:
  - Roll back, pulse o_drop, go to DROP.
- DROP: ignore beats; a tlast beat returns the FSM to IDLE.
- i_channel_up=0:
  - From RECV: roll back, pulse o_drop, go to IDLE.
  - From DROP: go to IDLE, with no second o_drop pulse.
  - Input beats are ignored while i_channel_up=0.
  - Committed frames keep draining.
- Free space: computed from the registered rd_ptr, so a read frees a slot one cycle later (conservative).
  - Simultaneous read and write is legal.
- Read side: synchronous memory read plus one output register; tvalid/tdata/tkeep/tlast are registered.
  - Output holds stable while tvalid=1 and tready=0.
  - Sustains 1 beat/cycle with tready held high.
- Latency: into an empty FIFO, the first beat of a frame shows m_axi_usr_tvalid=1 exactly 2 cycles after the edge that accepts the frame's tlast beat.
  - Single-beat frames are supported.
- Pointer wrap: the ADDR_W+1-bit pointers use the MSB to distinguish full from empty.
  - Frames larger than DEPTH are always dropped.
- tkeep is stored verbatim; no check on non-last beats.

Optional Feature:
- Macro: AURORA_RX_STATS_EN.
- Defined:
  - o_frame_cnt increments once per m_axi_usr tlast handshake.
  - o_drop_cnt increments once per o_drop pulse.
  - Both are 16-bit, saturate at 16'hFFFF, and reset to 0.
- Undefined:
  - Both outputs are tied to 0; no counter logic is synthesized.
  - o_drop is still present.

Test Plan:
- DEPTH=16, tready=1: send a 4-beat frame, data 0x00000001..0x00000004, last keep 4'b1100 -> 4 beats out unchanged, first tvalid 2 cycles after tlast; tlast on beat 4; o_free returns to 16.
- i_frame_err asserted on beat 2 of a 5-beat frame, followed by a good 2-beat frame -> only the 2-beat frame appears; one o_drop pulse; o_drop_cnt=1 (stats on).
- DEPTH=16, tready=0: 10-beat frame followed by 8-beat frame -> first frame stored; second overflows at beat 7 and is dropped; o_drop=1; wr_ptr rolled back; o_free=6; tready=1 drains exactly 10 beats.
- tready toggled in a 1010 pattern during a 6-beat frame -> data stable while stalled; no beat duplicated or lost.
- i_channel_up deasserted mid-frame, then a good frame sent after it re-asserts -> partial frame discarded; previously committed frames drained intact; new frame delivered.
- i_rst_n pulsed low while holding 2 committed frames -> tvalid=0 immediately; o_free=16; nothing emitted afterwards.

Source files
------------

// File: rtl/aurora_rx_frame_buffer_if.sv
// AXI-Stream bundle (tdata/tkeep/tlast/tvalid/tready) shared by the RX and user sides of the frame buffer.
// Latency: none, wiring only.
// Backpressure: carried by tready; the Aurora RX side has none, so its sink ties tready high.
interface aurora_rx_frame_buffer_if #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8
);
    // Bit 0 is the MSB to match the channel's [0:N] ordering.
    logic [0:DATA_W-1] tdata;
    logic [0:KEEP_W-1] tkeep;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward RX frame FIFO: only committed, error-free frames leave; optional counters under `AURORA_RX_STATS_EN.
// Latency: first beat valid 2 cycles after the edge that accepts tlast (empty FIFO); 1 beat/cycle sustained.
// Backpressure: none on RX (overflow drops the whole frame); output holds stable while tvalid && !tready.
module aurora_rx_frame_buffer #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    aurora_rx_frame_buffer_if.slave   s_axi_rx,
    input  logic                      i_frame_err,
    input  logic                      i_channel_up,
    aurora_rx_frame_buffer_if.master  m_axi_usr,
    output logic [ADDR_W:0]           o_free,
    output logic                      o_drop,
    output logic [15:0]               o_frame_cnt,
    output logic [15:0]               o_drop_cnt
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int ENT_W = DATA_W + KEEP_W + 1;

    // Write FSM encoding.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RECV = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // ------------------------------------------------------------------
    // Storage: each entry is {tdata, tkeep, tlast}.
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem [0:DEPTH-1];

    // Write side: wr_ptr advances per accepted beat, wr_commit only at a good tlast.
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] wr_commit;
    logic [PTR_W-1:0] wr_commit_nxt;
    logic             wr_en;
    logic             drop_nxt;
    logic [ENT_W-1:0] wr_ent;

    // Read side: rd_ptr counts words consumed downstream, fetch_ptr runs ahead
    // into the two-register output pipeline.
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fetch_ptr;
    logic             fetch_en;
    logic [ENT_W-1:0] rdq_ent;
    logic             rdq_vld;
    logic [ENT_W-1:0] out_ent;
    logic             out_vld;
    logic             out_load_en;
    logic             rdq_take;
    logic             out_hs;

    // Occupancy counts words still owed downstream, including those already
    // prefetched into the output pipeline, so free space stays conservative.
    logic [PTR_W-1:0] used;
    logic             full;
    logic             beat;

    assign used   = wr_ptr - rd_ptr;
    assign full   = (used == PTR_W'(DEPTH));
    assign o_free = PTR_W'(DEPTH) - used;
    assign beat   = s_axi_rx.tvalid;
    assign wr_ent = {s_axi_rx.tdata, s_axi_rx.tkeep, s_axi_rx.tlast};

    // The Aurora RX stream cannot be stalled.
    assign s_axi_rx.tready = 1'b1;

    // Next-state logic for the write FSM: accept, roll back, or discard.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        wr_en         = 1'b0;
        drop_nxt      = 1'b0;
        if (!i_channel_up) begin
            // Link loss: throw away the partial frame, ignore all input.
            if (state == ST_RECV) begin
                wr_ptr_nxt = wr_commit;
                drop_nxt   = 1'b1;
            end
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_RECV: begin
                    if (beat) begin
                        if (!full && !i_frame_err) begin
                            wr_en      = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_W'(1);
                            if (s_axi_rx.tlast) begin
                                wr_commit_nxt = wr_ptr + PTR_W'(1);
                                state_nxt     = ST_IDLE;
                            end else begin
                                state_nxt = ST_RECV;
                            end
                        end else begin
                            // Overflow or errored beat: the frame is lost.
                            wr_ptr_nxt = wr_commit;
                            drop_nxt   = 1'b1;
                            state_nxt  = s_axi_rx.tlast ? ST_IDLE : ST_DROP;
                        end
                    end else if (i_frame_err && (state == ST_RECV)) begin
                        wr_ptr_nxt = wr_commit;
                        drop_nxt   = 1'b1;
                        state_nxt  = ST_DROP;
                    end
                end
                ST_DROP: begin
                    // Swallow the remainder of a discarded frame.
                    if (beat && s_axi_rx.tlast) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Write-side registers: FSM, tentative/committed pointers and drop pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            o_drop    <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            o_drop    <= drop_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: memory read register (rdq) feeding the output register.
    // ------------------------------------------------------------------
    assign out_load_en = !out_vld || m_axi_usr.tready;
    assign rdq_take    = rdq_vld && out_load_en;
    assign fetch_en    = (fetch_ptr != wr_commit) && (!rdq_vld || rdq_take);
    assign out_hs      = out_vld && m_axi_usr.tready;

    // Storage array write port and registered read port (data needs no reset).
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_ent;
        end
        if (fetch_en) begin
            rdq_ent <= mem[fetch_ptr[ADDR_W-1:0]];
        end
    end

    // Fetch pointer and validity of the memory read register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_ptr <= '0;
            rdq_vld   <= 1'b0;
        end else if (fetch_en) begin
            fetch_ptr <= fetch_ptr + PTR_W'(1);
            rdq_vld   <= 1'b1;
        end else if (rdq_take) begin
            rdq_vld   <= 1'b0;
        end
    end

    // Output register: reloads only when empty or when the current beat is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_vld <= 1'b0;
            out_ent <= '0;
        end else if (out_load_en) begin
            out_vld <= rdq_vld;
            if (rdq_vld) begin
                out_ent <= rdq_ent;
            end
        end
    end

    // Consumed pointer: a slot is freed only once downstream takes the beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr <= '0;
        end else if (out_hs) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign m_axi_usr.tvalid = out_vld;
    assign m_axi_usr.tdata  = out_ent[ENT_W-1 -: DATA_W];
    assign m_axi_usr.tkeep  = out_ent[KEEP_W:1];
    assign m_axi_usr.tlast  = out_ent[0];

    // ------------------------------------------------------------------
    // Optional delivered/dropped frame counters.
    // ------------------------------------------------------------------
`ifdef AURORA_RX_STATS_EN
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    // Saturating counters: delivered frames on tlast handshake, drops on o_drop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            frame_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (out_hs && out_ent[0] && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (o_drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    assign o_frame_cnt = frame_cnt;
    assign o_drop_cnt  = drop_cnt;
`else
    assign o_frame_cnt = 16'd0;
    assign o_drop_cnt  = 16'd0;
`endif

endmodule
